// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: IDLE/REQ/DONE sequencer for loads and stores on a handshaked data bus.
// Optional MEM_TIMEOUT_EN adds a 256-cycle request timeout reported on mem_bus_err_o.
module mem_stage (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_store_data_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_mem_write_i,
    input  logic [1:0]  ex_mem_size_i,
    input  logic        ex_mem_unsigned_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_mem_to_reg_i,
    input  logic        ex_jal_i,
    input  logic [31:0] ex_pc_plus4_i,
    mem_stage_if.master dmem,
    output logic [31:0] mem_data_o,
    output logic [31:0] mem_alu_result_o,
    output logic [31:0] mem_pc_plus4_o,
    output logic [4:0]  mem_rd_o,
    output logic        mem_reg_write_o,
    output logic        mem_mem_to_reg_o,
    output logic        mem_jal_o,
    output logic        mem_stall_o,
    output logic        mem_misalign_o,
    output logic        mem_bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   calc_be = 4'b0001 << off;
            2'b01:   calc_be = off[1] ? 4'b1100 : 4'b0011;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   calc_wdata = {4{data[7:0]}};
            2'b01:   calc_wdata = {2{data[15:0]}};
            default: calc_wdata = data;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (size)
            2'b00:   extend_load = uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   extend_load = uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: extend_load = rdata;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, alu_q, pc_q, data_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q;
    logic [4:0]  rd_q;
    logic        we_q, uns_q, rw_q, m2r_q, jal_q;

    logic        is_mem_s, misaligned_s, start_s, capture_s, timeout_s, err_s;
    logic        stall_s, misalign_s, req_s, rw_s, jal_s, m2r_s;
    logic [31:0] data_s, alu_s, pc_s;
    logic [4:0]  rd_s;

    assign is_mem_s     = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
    assign misaligned_s = ((ex_mem_size_i == 2'b01) & ex_alu_result_i[0]) |
                          (ex_mem_size_i[1] & (ex_alu_result_i[1:0] != 2'b00));

    // State register and transaction latches.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            alu_q   <= 32'd0;
            pc_q    <= 32'd0;
            data_q  <= 32'd0;
            be_q    <= 4'd0;
            size_q  <= 2'd0;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            jal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_s) begin
                addr_q  <= ex_alu_result_i;
                wdata_q <= calc_wdata(ex_mem_size_i, ex_store_data_i);
                be_q    <= calc_be(ex_mem_size_i, ex_alu_result_i[1:0]);
                alu_q   <= ex_alu_result_i;
                pc_q    <= ex_pc_plus4_i;
                size_q  <= ex_mem_size_i;
                rd_q    <= ex_rd_i;
                we_q    <= ex_mem_write_i;
                uns_q   <= ex_mem_unsigned_i;
                rw_q    <= ex_reg_write_i;
                m2r_q   <= ex_mem_to_reg_i;
                jal_q   <= ex_jal_i;
                data_q  <= 32'd0;
            end
            if (capture_s) begin
                data_q <= we_q ? 32'd0 : extend_load(dmem.dmem_rdata, addr_q[1:0], size_q, uns_q);
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_q;
    logic       err_q;

    // Count unacknowledged REQ cycles; the 256th one without ack aborts the access.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else if (start_s) begin
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else if ((state_q == S_REQ) && !dmem.dmem_ack) begin
            if (wait_cnt_q == 8'hFF) begin
                err_q <= 1'b1;
            end else begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
        end
    end

    assign timeout_s     = (wait_cnt_q == 8'hFF);
    assign err_s         = err_q;
    assign mem_bus_err_o = (state_q == S_DONE) & err_q & ~reset_i;
`else
    assign timeout_s     = 1'b0;
    assign err_s         = 1'b0;
    assign mem_bus_err_o = 1'b0;
`endif

    // Next state and MEM/WB-facing outputs; pass-through unless a memory access is in flight.
    always_comb begin
        state_d   = state_q;
        start_s   = 1'b0;
        capture_s = 1'b0;
        stall_s   = 1'b0;
        misalign_s = 1'b0;
        req_s     = 1'b0;
        data_s    = 32'd0;
        alu_s     = ex_alu_result_i;
        pc_s      = ex_pc_plus4_i;
        rd_s      = ex_rd_i;
        m2r_s     = ex_mem_to_reg_i;
        rw_s      = ex_valid_i & ex_reg_write_i;
        jal_s     = ex_valid_i & ex_jal_i;
        case (state_q)
            S_IDLE: begin
                if (is_mem_s) begin
                    rw_s  = 1'b0;
                    jal_s = 1'b0;
                    if (misaligned_s) begin
                        misalign_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                        start_s = 1'b1;
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                rw_s    = 1'b0;
                jal_s   = 1'b0;
                alu_s   = alu_q;
                pc_s    = pc_q;
                rd_s    = rd_q;
                m2r_s   = m2r_q;
                if (dmem.dmem_ack) begin
                    capture_s = 1'b1;
                    state_d   = S_DONE;
                end else if (timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                alu_s   = alu_q;
                pc_s    = pc_q;
                rd_s    = rd_q;
                m2r_s   = m2r_q;
                rw_s    = rw_q & ~err_s;
                jal_s   = jal_q;
                data_s  = data_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and error outputs drop asynchronously while reset is held.
    assign mem_stall_o    = stall_s & ~reset_i;
    assign mem_misalign_o = misalign_s & ~reset_i;
    assign dmem.dmem_req  = req_s & ~reset_i;
    assign dmem.dmem_we   = we_q;
    assign dmem.dmem_addr = {addr_q[31:2], 2'b00};
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be   = be_q;

    assign mem_data_o       = data_s;
    assign mem_alu_result_o = alu_s;
    assign mem_pc_plus4_o   = pc_s;
    assign mem_rd_o         = rd_s;
    assign mem_reg_write_o  = rw_s;
    assign mem_mem_to_reg_o = m2r_s;
    assign mem_jal_o        = jal_s;

endmodule
